// File: rtl/csa_seq_pkg.sv
//------------------------------------------------------------------------------
// csa_seq_pkg : shared FSM encodings and slice default for the wide adder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package csa_seq_pkg;

  localparam int c_slice_dflt = 8;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

endpackage

`default_nettype wire

// File: rtl/csa_slice_adder.sv
//------------------------------------------------------------------------------
// csa_slice_adder : combinational carry-select adder of SLICE bits
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csa_slice_adder
  import csa_seq_pkg::*;
#(
  parameter int SLICE = c_slice_dflt
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  localparam int c_lo = SLICE / 2;
  localparam int c_hi = SLICE - c_lo;

  generate
    if (SLICE < 2) begin : g_slice_check
      $error("csa_slice_adder: SLICE must be at least 2");
    end
  endgenerate

  logic [c_lo:0] w_lo;
  logic [c_hi:0] w_hi0;
  logic [c_hi:0] w_hi1;

  assign w_lo  = {1'b0, a[c_lo-1:0]} + {1'b0, b[c_lo-1:0]} + {{c_lo{1'b0}}, ci};
  // Upper half is precomputed for both possible carries, then selected.
  assign w_hi0 = {1'b0, a[SLICE-1:c_lo]} + {1'b0, b[SLICE-1:c_lo]};
  assign w_hi1 = {1'b0, a[SLICE-1:c_lo]} + {1'b0, b[SLICE-1:c_lo]} + {{c_hi{1'b0}}, 1'b1};

  assign s  = {(w_lo[c_lo] ? w_hi1[c_hi-1:0] : w_hi0[c_hi-1:0]), w_lo[c_lo-1:0]};
  assign co = w_lo[c_lo] ? w_hi1[c_hi] : w_hi0[c_hi];

endmodule

`default_nettype wire

// File: rtl/csa_seq_wide_adder.sv
//------------------------------------------------------------------------------
// csa_seq_wide_adder : WIDTH-bit adder built by feeding one slice per cycle,
// LSB first, through csa_slice_adder. Option macro: CSA_SEQ_OVF_EN (ovf port).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csa_seq_wide_adder
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = c_slice_dflt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] c_last = IDXW'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("csa_seq_wide_adder: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [SLICE-1:0] w_s;
  logic             w_co;
  logic             w_last;

  assign w_last = (r_idx == c_last);

  csa_slice_adder #(.SLICE(SLICE)) u_slice (
    .a  (r_a[r_idx*SLICE +: SLICE]),
    .b  (r_b[r_idx*SLICE +: SLICE]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_state_nxt = c_run;
      c_run:   if (w_last)    w_state_nxt = c_done;
      c_done:  if (out_ready) w_state_nxt = c_idle;
      default:                w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
  end

  // Carry between slices only ever travels through r_carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_idx   <= '0;
          r_sum   <= '0;
          r_cout  <= 1'b0;
        end
        c_run: begin
          r_sum[r_idx*SLICE +: SLICE] <= w_s;
          r_carry <= w_co;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_co;
          end else begin
            r_idx  <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef CSA_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == c_idle && in_valid) begin
      r_ovf <= 1'b0;
    end else if (r_state == c_run && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[SLICE-1] != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_seq_wide_adder.sv
//------------------------------------------------------------------------------
// tb_csa_seq_wide_adder : scoreboard bench for csa_seq_wide_adder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_csa_seq_wide_adder;

  localparam int W  = 32;
  localparam int NS = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_SEQ_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  csa_seq_wide_adder #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one operation for one edge, queues the expected result.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    int   n;
    logic [W:0] full;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    full   = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
  endtask

  // Called at the negedge right after acceptance; checks latency when exp_lat >= 0.
  task automatic recv(input string tag, input int exp_lat, output int lows);
    int   lat;
    exp_t e;
    lat  = 0;
    lows = 0;
    while (!out_valid && lat < 50) begin
      if (!in_ready) lows++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready) lows++;
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    else              check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"},  64'(sum),  64'(e.sum));
      check({tag, "_cout"}, 64'(cout), 64'(e.cout));
`ifdef CSA_SEQ_OVF_EN
      check({tag, "_ovf"},  64'(ovf),  64'(e.ovf));
`endif
    end
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    int lows;
    #12;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       64'(sum),  64'd0);
    check("rst_cout",      64'(cout), 64'd0);
`ifdef CSA_SEQ_OVF_EN
    check("rst_ovf",       64'(ovf),  64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, latency and busy window
    send(32'h0000000F, 32'h0000000A, 1'b0);
    recv("t1", NS, lows);
    check("t1_busy", 64'(lows), 64'd5);
    check("t1_idle", {63'd0, in_ready}, 64'd1);

    send(32'h000000FF, 32'h00000001, 1'b0);
    recv("t2", NS, lows);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1);
    recv("t3", NS, lows);

    // Output stall with a competing request that must be ignored
    out_ready = 1'b0;
    send(32'h000000C8, 32'h00000037, 1'b1);
    recv("t4", NS, lows);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b1;
      @(negedge clk);
      check("t4_stall_sum",   64'(sum),  64'h100);
      check("t4_stall_cout",  64'(cout), 64'd0);
      check("t4_stall_ready", {63'd0, in_ready},  64'd0);
      check("t4_stall_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_ready", {63'd0, in_ready},  64'd1);
    check("t4_release_valid", {63'd0, out_valid}, 64'd0);
    send(32'hDEADBEEF, 32'h01010101, 1'b1);
    recv("t4b", NS, lows);

    // Reset while idx==2
    send(32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_valid", {63'd0, out_valid}, 64'd0);
    check("t5_sum",   64'(sum),  64'd0);
    check("t5_cout",  64'(cout), 64'd0);
    check("t5_ready", {63'd0, in_ready}, 64'd1);
    void'(exp_q.pop_back());
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_pulse", {63'd0, out_valid}, 64'd0);
    end
    send(32'h00000064, 32'h0000009B, 1'b0);
    recv("t5b", NS, lows);

    // Signed overflow cases (ovf only checked when the port exists)
    send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    recv("t6a", NS, lows);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0);
    recv("t6b", NS, lows);

    // Random back-to-back traffic
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(1)));
      recv("rnd", NS, lows);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
